// File: rtl/sumador_serie_nibbles_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package sumador_serie_nibbles_pkg;

  localparam int NIBBLE = 4;

  // Code 2'd3 is unused and falls back to REPOSO in the next-state logic
  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    SUMANDO   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

endpackage

// File: rtl/sumadorCarryLook_4bits.sv
// 4-bit carry-lookahead adder used as the nibble adder by sumador_serie_nibbles.
module sumadorCarryLook_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Every carry is expanded from generate/propagate terms instead of rippling
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = Ci;
    c[1] = g[0] | (p[0] & Ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & Ci);
    S    = p ^ c[3:0];
    Co   = c[4];
  end

endmodule

// File: rtl/sumador_serie_nibbles.sv
// ANCHO-bit adder that feeds one nibble per cycle through a single 4-bit CLA, LSB first.
// Optional macro SUMADOR_SERIE_OVERFLOW_EN adds the two's-complement overflow output Ov.
module sumador_serie_nibbles
  import sumador_serie_nibbles_pkg::*;
#(
  parameter  int ANCHO   = 16,
  localparam int NIBBLES = ANCHO / NIBBLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic             Ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANCHO-1:0] S,
  output logic             Co
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  ,
  output logic             Ov
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  estado_t          estado;
  estado_t          estado_sig;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
  logic [ANCHO-1:0] s_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             ultimo;
  logic [3:0]       nib_s;
  logic             nib_co;

  assign ultimo = (idx == IW'(NIBBLES - 1));

  // Operands are shifted right each pass, so the active nibble always sits in bits [3:0]
  sumadorCarryLook_4bits u_nibble (
    .A  (op_a[NIBBLE-1:0]),
    .B  (op_b[NIBBLE-1:0]),
    .Ci (carry),
    .S  (nib_s),
    .Co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (estado)
      REPOSO: begin
        in_ready = 1'b1;
        if (in_valid) estado_sig = SUMANDO;
      end
      SUMANDO: begin
        if (ultimo) estado_sig = RESULTADO;
      end
      RESULTADO: begin
        out_valid = 1'b1;
        if (out_ready) estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (in_valid) begin
            op_a  <= A;
            op_b  <= B;
            carry <= Ci;
            idx   <= '0;
          end
        end
        SUMANDO: begin
          s_reg[NIBBLE*idx +: NIBBLE] <= nib_s;
          carry <= nib_co;
          op_a  <= op_a >> NIBBLE;
          op_b  <= op_b >> NIBBLE;
          idx   <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign S  = s_reg;
  assign Co = carry;

`ifdef SUMADOR_SERIE_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
  logic ov_reg;

  // Operand sign bits are kept aside because the operand registers get shifted away
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ov_reg <= 1'b0;
    end else if (estado == REPOSO && in_valid) begin
      a_msb <= A[ANCHO-1];
      b_msb <= B[ANCHO-1];
    end else if (estado == SUMANDO && ultimo) begin
      ov_reg <= (a_msb == b_msb) && (nib_s[NIBBLE-1] != a_msb);
    end
  end

  assign Ov = ov_reg;
`endif

endmodule

// File: tb/tb_sumador_serie_nibbles.sv
// Self-checking bench for sumador_serie_nibbles (ANCHO=16) against an arithmetic reference model.
module tb_sumador_serie_nibbles;

  localparam int ANCHO   = 16;
  localparam int NIBBLES = ANCHO / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] A;
  logic [ANCHO-1:0] B;
  logic             Ci;
  logic             out_valid;
  logic             out_ready;
  logic [ANCHO-1:0] S;
  logic             Co;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  logic             Ov;
`endif

  typedef struct {
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic             ci;
  } op_t;

  typedef struct {
    logic [ANCHO-1:0] s;
    logic             co;
    logic             ov;
  } res_t;

  op_t  pending[$];
  res_t expq[$];
  int   nChecks = 0;
  int   nPass   = 0;

  sumador_serie_nibbles #(.ANCHO(ANCHO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co)
`ifdef SUMADOR_SERIE_OVERFLOW_EN
    ,
    .Ov        (Ov)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, overflow as signed sum out of range
  function automatic res_t modelo(input op_t o);
    res_t   r;
    longint total;
    longint sa;
    longint sb;
    longint ssum;
    total = longint'(o.a) + longint'(o.b) + longint'(o.ci);
    r.s   = total[ANCHO-1:0];
    r.co  = total[ANCHO];
    sa    = o.a[ANCHO-1] ? longint'(o.a) - (longint'(1) << ANCHO) : longint'(o.a);
    sb    = o.b[ANCHO-1] ? longint'(o.b) - (longint'(1) << ANCHO) : longint'(o.b);
    ssum  = sa + sb + longint'(o.ci);
    r.ov  = (ssum > ((longint'(1) << (ANCHO-1)) - 1)) || (ssum < -(longint'(1) << (ANCHO-1)));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp)
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    else
      nPass++;
  endtask

  task automatic pushOp(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b, input logic ci);
    op_t o;
    o.a = a;
    o.b = b;
    o.ci = ci;
    pending.push_back(o);
  endtask

  // readyMode: 0 = out_ready always high, 1 = random, 2 = low for 3 valid cycles then high
  task automatic applyStimulus(input int readyMode, input bit junk, input int maxCycles);
    int cyc = 0;
    int accCyc = -1000;
    int lastAcc = -1000;
    int heldCycles = 0;
    bit busy = 1'b0;
    bit release_next = 1'b0;
    bit expValid;
    while ((pending.size() > 0 || expq.size() > 0 || busy) && cyc < maxCycles) begin
      @(negedge clk);
      cyc++;
      if (release_next) begin
        busy = 1'b0;
        release_next = 1'b0;
      end
      checkOutput("in_ready", in_ready, !busy);
      expValid = busy && (cyc - accCyc >= NIBBLES + 1);
      checkOutput("out_valid", out_valid, expValid);
      if (expValid && expq.size() > 0) begin
        checkOutput("S", S, expq[0].s);
        checkOutput("Co", Co, expq[0].co);
`ifdef SUMADOR_SERIE_OVERFLOW_EN
        checkOutput("Ov", Ov, expq[0].ov);
`endif
        heldCycles++;
      end
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (heldCycles >= 4);
      endcase
      if (expValid && out_ready && expq.size() > 0) begin
        void'(expq.pop_front());
        release_next = 1'b1;
        heldCycles = 0;
      end
      if (!busy && pending.size() > 0) begin
        A = pending[0].a;
        B = pending[0].b;
        Ci = pending[0].ci;
        in_valid = 1'b1;
        expq.push_back(modelo(pending[0]));
        void'(pending.pop_front());
        if (lastAcc > 0)
          checkOutput("accept_gap_ok", (cyc - lastAcc) >= NIBBLES + 2, 1'b1);
        lastAcc = cyc;
        accCyc = cyc;
        busy = 1'b1;
      end else if (busy && pending.size() > 0) begin
        A = pending[0].a;
        B = pending[0].b;
        Ci = pending[0].ci;
        in_valid = 1'b1;
      end else if (busy && junk) begin
        A = ANCHO'($urandom);
        B = ANCHO'($urandom);
        Ci = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("stream_drained", pending.size() + expq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    Ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_S", S, 0);
    checkOutput("rst_Co", Co, 1'b0);
`ifdef SUMADOR_SERIE_OVERFLOW_EN
    checkOutput("rst_Ov", Ov, 1'b0);
`endif

    pushOp(16'h1234, 16'h4321, 1'b0);
    applyStimulus(0, 1'b0, 100);

    pushOp(16'hFFFF, 16'h0001, 1'b0);
    pushOp(16'h00FF, 16'h0000, 1'b1);
    applyStimulus(0, 1'b0, 100);

    pushOp(16'hABCD, 16'h1111, 1'b0);
    applyStimulus(2, 1'b1, 100);

    pushOp(16'h1234, 16'h4321, 1'b0);
    pushOp(16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(0, 1'b0, 100);

    // Reset asserted during the second SUMANDO cycle discards the operation
    @(negedge clk);
    A = 16'h5A5A;
    B = 16'h0F0F;
    Ci = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_S", S, 0);
    checkOutput("midrst_Co", Co, 1'b0);
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_result", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    pushOp(16'h0001, 16'h0001, 1'b0);
    applyStimulus(0, 1'b0, 100);

    pushOp(16'h7FFF, 16'h0001, 1'b0);
    pushOp(16'hFFFF, 16'h0001, 1'b0);
    pushOp(16'h8000, 16'h8000, 1'b0);
    applyStimulus(1, 1'b1, 200);

    for (int i = 0; i < 30; i++)
      pushOp(ANCHO'($urandom), ANCHO'($urandom), 1'($urandom_range(0, 1)));
    applyStimulus(1, 1'b1, 2000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
